// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - 8N1 UART program loader writing {opcode, operand} words to program memory
// Optional feature macro: LOADER_CHECKSUM_EN (trailing 8-bit checksum byte verified before DONE).
module prog_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         ADDR_WIDTH   = 8,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  prog_we,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [15:0]           prog_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]         HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]         FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]         TMR_ONE  = CW'(1);
  localparam logic [ADDR_WIDTH:0]   WORD_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   WORD_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t     rx_state, rx_state_next;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          tick;
  logic          byte_valid, frame_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Start bit is checked at mid-bit; every later sample lands a full bit later.
  always_comb begin
    tick          = (rx_state == RX_START) ? (bit_timer == HALF_M1) : (bit_timer == FULL_M1);
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_state_next = RX_START;
      RX_START: if (tick) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (tick) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      bit_timer  <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_next;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state == RX_IDLE || tick) bit_timer <= '0;
      else bit_timer <= bit_timer + TMR_ONE;
      if (rx_state == RX_DATA && tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
      if (rx_state == RX_STOP && tick) begin
        byte_valid <= rx_sync;
        frame_err  <= !rx_sync;
      end
    end
  end

  // ---------------- Load frame FSM ----------------
  typedef enum logic [2:0] {
    IDLE, WAIT_COUNT, RECV_HI, RECV_LO, WRITE, RECV_CSUM, DONE, ERROR
  } state_t;
  state_t              state, state_next;
  logic [ADDR_WIDTH:0] words_left;
  logic [7:0]          hi_byte;
  logic                start_load;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum;
`endif

  always_comb begin
    state_next = state;
    start_load = (state inside {IDLE, DONE, ERROR}) && byte_valid && (rx_shift == HEADER);
    case (state)
      IDLE, DONE, ERROR: if (start_load) state_next = WAIT_COUNT;
      WAIT_COUNT: if (byte_valid) state_next = RECV_HI;
      RECV_HI:    if (byte_valid) state_next = RECV_LO;
      RECV_LO:    if (byte_valid) state_next = WRITE;
      WRITE: begin
        if (words_left != WORD_ONE) state_next = RECV_HI;
`ifdef LOADER_CHECKSUM_EN
        else state_next = RECV_CSUM;
`else
        else state_next = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      RECV_CSUM: if (byte_valid) state_next = (rx_shift == sum) ? DONE : ERROR;
`endif
      default: state_next = IDLE;
    endcase
    if (frame_err && !(state inside {IDLE, DONE, ERROR})) state_next = ERROR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      words_left <= '0;
      hi_byte    <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state   <= state_next;
      prog_we <= (state == RECV_LO) && (state_next == WRITE);
      if (start_load) begin
        cpu_hold  <= 1'b1;
        load_done <= 1'b0;
        load_err  <= 1'b0;
        prog_addr <= '0;
      end
      // A COUNT byte of zero stands for a full memory image.
      if (state == WAIT_COUNT && byte_valid)
        words_left <= (rx_shift == 8'd0) ? WORD_MAX : (ADDR_WIDTH + 1)'(rx_shift);
      if (state == RECV_HI && byte_valid) hi_byte <= rx_shift;
      if (state == RECV_LO && byte_valid) prog_data <= {hi_byte, rx_shift};
      if (state == WRITE) begin
        prog_addr  <= prog_addr + ADDR_ONE;
        words_left <= words_left - WORD_ONE;
      end
      if (state_next == DONE && state != DONE) begin
        cpu_hold  <= 1'b0;
        load_done <= 1'b1;
      end
      if (state_next == ERROR && state != ERROR) load_err <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (start_load) sum <= '0;
      else if (byte_valid && (state inside {WAIT_COUNT, RECV_HI, RECV_LO})) sum <= sum + rx_shift;
`endif
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
// Honours LOADER_CHECKSUM_EN: checksum bytes and the bad-checksum case only in that build.
module tb_prog_loader;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic        cpu_hold, load_done, load_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  wr_addr[$];
  logic [15:0] wr_data[$];

  prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8), .HEADER(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prog_we) begin
      wr_addr.push_back(prog_addr);
      wr_data.push_back(prog_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_q();
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b1);
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    logic [7:0] csum;
    int bad;
    repeat (3) @(negedge clk);
    check("rst_we", prog_we, 0);
    check("rst_addr", prog_addr, 0);
    check("rst_data", prog_data, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Two-word frame; checksum 02+10+05+20+07 = 3E
    clear_writes();
    tx_q = '{8'hA5, 8'h02};
    send_q();
    check("t1_hold_mid", cpu_hold, 1);
    check("t1_done_mid", load_done, 0);
    tx_q = '{8'h10, 8'h05, 8'h20, 8'h07};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h3E);
`endif
    send_q();
    check("t1_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t1_a0", wr_addr[0], 8'h00);
      check("t1_d0", wr_data[0], 16'h1005);
      check("t1_a1", wr_addr[1], 8'h01);
      check("t1_d1", wr_data[1], 16'h2007);
    end
    check("t1_done", load_done, 1);
    check("t1_hold", cpu_hold, 0);
    check("t1_err", load_err, 0);
    check("t1_addr", prog_addr, 8'h02);

`ifdef LOADER_CHECKSUM_EN
    clear_writes();
    tx_q = '{8'hA5, 8'h02, 8'h10, 8'h05, 8'h20, 8'h07, 8'h3D};
    send_q();
    check("t2_nwr", wr_addr.size(), 2);
    check("t2_err", load_err, 1);
    check("t2_hold", cpu_hold, 1);
    check("t2_done", load_done, 0);
`endif

    // Leading non-header bytes are ignored; checksum 01+AB+CD = 79
    clear_writes();
    tx_q = '{8'h11, 8'h22, 8'hA5, 8'h01, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h79);
`endif
    send_q();
    check("t3_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("t3_a0", wr_addr[0], 8'h00);
      check("t3_d0", wr_data[0], 16'hABCD);
    end
    check("t3_done", load_done, 1);
    check("t3_err", load_err, 0);
    check("t3_hold", cpu_hold, 0);

    // Short low glitch, then a frame right behind it must still decode cleanly
    clear_writes();
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("t5_nwr_glitch", wr_addr.size(), 0);
    check("t5_done", load_done, 1);
    check("t5_hold", cpu_hold, 0);
    tx_q = '{8'hA5, 8'h01, 8'h12, 8'h34};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h47);
`endif
    send_q();
    check("t5_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) check("t5_d0", wr_data[0], 16'h1234);
    check("t5_done2", load_done, 1);

    // Framing error on a lo byte
    clear_writes();
    tx_q = '{8'hA5, 8'h02, 8'h10, 8'h05, 8'h20};
    send_q();
    send_byte(8'h07, 1'b0);
    check("t4_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) check("t4_d0", wr_data[0], 16'h1005);
    check("t4_err", load_err, 1);
    check("t4_hold", cpu_hold, 1);
    check("t4_done", load_done, 0);
    check("t4_addr", prog_addr, 8'h01);

    // Full 256-word image with COUNT=00
    clear_writes();
    tx_q = '{8'hA5, 8'h00};
    csum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      tx_q.push_back(8'(i));
      tx_q.push_back(8'(i) ^ 8'h5A);
      csum = csum + 8'(i) + (8'(i) ^ 8'h5A);
    end
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(csum);
`endif
    send_q();
    check("t6_nwr", wr_addr.size(), 256);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== {8'(i), 8'(i) ^ 8'h5A}) bad++;
    check("t6_bad_words", bad, 0);
    if (wr_addr.size() == 256) begin
      check("t6_last_a", wr_addr[255], 8'hFF);
      check("t6_last_d", wr_data[255], 16'hFFA5);
    end
    check("t6_addr_wrap", prog_addr, 8'h00);
    check("t6_done", load_done, 1);
    check("t6_hold", cpu_hold, 0);

    // Reset in the middle of a frame
    clear_writes();
    tx_q = '{8'hA5, 8'h00, 8'h11, 8'h22};
    send_q();
    check("t7_hold_mid", cpu_hold, 1);
    check("t7_addr_mid", prog_addr, 8'h01);
    reset = 1'b1;
    #1;
    check("t7_we", prog_we, 0);
    check("t7_addr", prog_addr, 0);
    check("t7_data", prog_data, 0);
    check("t7_hold", cpu_hold, 0);
    check("t7_done", load_done, 0);
    check("t7_err", load_err, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    clear_writes();
    tx_q = '{8'hA5, 8'h01, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h78);
`endif
    send_q();
    check("t7_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("t7_a0", wr_addr[0], 8'h00);
      check("t7_d0", wr_data[0], 16'h3344);
    end
    check("t7_done2", load_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
